finn_rtl_krnl_example_stream_scheduler: RTL and testbench
=========================================================

// Module: finn_rtl_krnl_example_stream_scheduler
// PURPOSE
//  Sequences C_NUM_STREAMS number generators for C_NUM_ROUNDS rounds. Each round it pulses gen_start to all
//  generators, then merges their AXI4-Stream outputs onto one master stream, packet-granular round-robin.
//  Sits between the generator bank and the kernel output stream; owns kernel ap_start/ap_done.
// PARAMETERS
//  C_NUM_STREAMS         4    generator streams merged, 2..16
//  C_M_AXIS_TDATA_WIDTH  128  tdata width of every stream, multiple of 8
//  C_NUM_ROUNDS          2    generator start rounds per ap_start, >=1
// PORTS
//  aclk           in   1                     clock, all logic rising-edge
//  areset_n       in   1                     asynchronous active-low reset
//  ap_start       in   1                     level; sampled only in IDLE
//  ap_idle        out  1                     high in IDLE
//  ap_done        out  1                     1-cycle pulse, end of final round
//  gen_start      out  1                     1-cycle start pulse to all generators
//  s_axis_tvalid  in   C_NUM_STREAMS         per-stream valid
//  s_axis_tready  out  C_NUM_STREAMS         per-stream ready
//  s_axis_tdata   in   C_NUM_STREAMS*W       stream i at [i*W +: W], W=C_M_AXIS_TDATA_WIDTH
//  s_axis_tkeep   in   C_NUM_STREAMS*W/8     stream i at [i*W/8 +: W/8]
//  s_axis_tlast   in   C_NUM_STREAMS         per-stream last
//  m_axis_tvalid  out  1 / m_axis_tready in 1 / m_axis_tdata out W / m_axis_tkeep out W/8 / m_axis_tlast out 1
// BEHAVIOUR
//  Reset (async assert, sync release): state IDLE, ap_idle=1, ap_done=0, gen_start=0, s_axis_tready=0,
//   m_axis_tvalid=0, served=0, round_cnt=0, last_grant=C_NUM_STREAMS-1. Reset mid-packet abandons it silently.
//  FSM: IDLE -> START (ap_start=1) -> ARB -> XFER -> ARB ... -> START (next round) | DONE -> IDLE.
//  IDLE: ap_idle=1; ap_start=1 -> START, round_cnt=0, served=0. ap_start outside IDLE ignored.
//  START: gen_start=1 for exactly this cycle, then ARB; gen_start always low >=1 cycle between pulses.
//  ARB (1 cycle min): candidates = ~served & s_axis_tvalid; grant first candidate after last_grant, cyclic,
//   wrapping C_NUM_STREAMS-1 -> 0; register grant, last_grant<=grant, -> XFER. No candidate: stay in ARB.
//  XFER: combinational mux: m_axis_{tvalid,tdata,tkeep,tlast} = stream[grant];
//   s_axis_tready[grant] = m_axis_tready, all others 0. Zero added latency on data path.
//   Beat with m_axis_tvalid & m_axis_tready & m_axis_tlast: served[grant]<=1; if all served:
//   round_cnt==C_NUM_ROUNDS-1 -> DONE else round_cnt++, served<=0, -> START; otherwise -> ARB.
//  Grant held for a whole packet (locked until tlast accepted); no interleave; tvalid drop mid-packet just stalls.
//  Outside XFER: m_axis_tvalid=0, m_axis_tdata/tkeep/tlast=0, all s_axis_tready=0.
//  DONE: ap_done=1 one cycle, -> IDLE; ap_start still high re-starts from IDLE next cycle.
//  Each stream served exactly once per round; a served stream asserting tvalid is not granted that round.
//  round_cnt width $clog2(C_NUM_ROUNDS+1); grant/last_grant width $clog2(C_NUM_STREAMS).
// STRUCTURE
//  Package finn_rtl_krnl_example_pkg: state enum (IDLE,START,ARB,XFER,DONE), helper function
//   to compute index widths.
//  Sub-module finn_rtl_krnl_example_rr_arbiter #(C_N): req[C_N], last_grant in -> grant_valid, grant idx out;
//   purely combinational rotate-priority encoder. FSM, counters and mux stay in this module.
// TESTING
//  1 N=4,R=1, all streams valid, 3-beat packets, m_axis_tready=1 -> grant order 0,1,2,3;
//    12 beats out, one idle ARB cycle between packets, ap_done pulse 1 cycle after stream 3 tlast.
//  2 R=2 -> exactly 2 gen_start pulses, low between; second round order continues from last_grant:
//    0,1,2,3 then 0,1,2,3; 24 beats total.
//  3 Only stream 2 valid initially, stream 0 valid 10 cycles later -> order 2,3?(when valid),0...;
//    ARB waits with m_axis_tvalid=0 while no candidate.
//  4 Random m_axis_tready backpressure (50%) -> tdata/tkeep/tlast stable while tvalid&!tready;
//    no beat lost/duplicated; non-granted s_axis_tready always 0.
//  5 areset_n low mid-packet of stream 1 -> all outputs at reset values immediately (async);
//    after release ap_idle=1, next ap_start starts fresh round with grant 0.
//  6 ap_start held high through whole run -> ignored while busy; new run starts the cycle after
//    IDLE re-entered; tkeep of partial last beat forwarded unchanged.

Source files
------------

// File: rtl/finn_rtl_krnl_example_pkg.sv
// Shared types and helpers for the example stream-scheduler kernel.
//   state_t   : scheduler FSM states
//   idx_width : bit width needed to index n items (at least 1 bit)
package finn_rtl_krnl_example_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_ARB,
    ST_XFER,
    ST_DONE
  } state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/finn_rtl_krnl_example_rr_arbiter.sv
// Rotate-priority encoder used by the stream scheduler.
// Ports:
//   req         in  C_N   requesting streams
//   last_grant  in  IW    index granted most recently; search starts just after it
//   grant_valid out 1     at least one request present
//   grant       out IW    first requester after last_grant, wrapping C_N-1 -> 0
// Purely combinational; the caller registers the result.
module finn_rtl_krnl_example_rr_arbiter
  import finn_rtl_krnl_example_pkg::*;
#(
  parameter int C_N = 4,
  parameter int IW  = idx_width(C_N)
) (
  input  logic [C_N-1:0] req,
  input  logic [IW-1:0]  last_grant,
  output logic           grant_valid,
  output logic [IW-1:0]  grant
);

  logic [IW-1:0] idx;

  // Walk offsets 1..C_N from last_grant; offset C_N revisits last_grant itself,
  // so a lone requester that was also the previous winner is still granted.
  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    idx         = '0;
    for (int k = 1; k <= C_N; k++) begin
      idx = IW'((int'(last_grant) + k) % C_N);
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant       = idx;
      end
    end
  end

endmodule

// File: rtl/finn_rtl_krnl_example_stream_scheduler.sv
// Kernel-level scheduler: runs C_NUM_ROUNDS generator rounds per ap_start and
// merges the generator AXI4-Stream outputs onto one master stream, one whole
// packet per grant, round-robin, each stream exactly once per round.
// Ports:
//   aclk, areset_n         clock / asynchronous active-low reset
//   ap_start/ap_idle/ap_done kernel handshake (ap_done is a 1-cycle pulse)
//   gen_start              1-cycle start pulse to every generator
//   s_axis_*               C_NUM_STREAMS packed slave streams, stream i at slice i
//   m_axis_*               merged master stream (combinational mux, no added latency)
module finn_rtl_krnl_example_stream_scheduler
  import finn_rtl_krnl_example_pkg::*;
#(
  parameter int C_NUM_STREAMS        = 4,
  parameter int C_M_AXIS_TDATA_WIDTH = 128,
  parameter int C_NUM_ROUNDS         = 2
) (
  input  logic                                                aclk,
  input  logic                                                areset_n,
  input  logic                                                ap_start,
  output logic                                                ap_idle,
  output logic                                                ap_done,
  output logic                                                gen_start,
  input  logic [C_NUM_STREAMS-1:0]                            s_axis_tvalid,
  output logic [C_NUM_STREAMS-1:0]                            s_axis_tready,
  input  logic [C_NUM_STREAMS*C_M_AXIS_TDATA_WIDTH-1:0]       s_axis_tdata,
  input  logic [C_NUM_STREAMS*(C_M_AXIS_TDATA_WIDTH/8)-1:0]   s_axis_tkeep,
  input  logic [C_NUM_STREAMS-1:0]                            s_axis_tlast,
  output logic                                                m_axis_tvalid,
  input  logic                                                m_axis_tready,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]                     m_axis_tdata,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]                   m_axis_tkeep,
  output logic                                                m_axis_tlast
);

  localparam int N  = C_NUM_STREAMS;
  localparam int W  = C_M_AXIS_TDATA_WIDTH;
  localparam int KW = W / 8;
  localparam int GW = idx_width(N);
  localparam int RW = $clog2(C_NUM_ROUNDS + 1);

  state_t        state_q, state_d;
  logic [N-1:0]  served_q, served_d;
  logic [RW-1:0] round_q, round_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] last_grant_q, last_grant_d;

  logic          arb_valid;
  logic [GW-1:0] arb_grant;
  logic [N-1:0]  grant_oh;
  logic [N-1:0]  served_now;
  logic          pkt_end;

  // Streams already served this round are masked out of arbitration even if
  // their generator is already offering the next round's packet.
  finn_rtl_krnl_example_rr_arbiter #(
    .C_N (N),
    .IW  (GW)
  ) u_arb (
    .req         (~served_q & s_axis_tvalid),
    .last_grant  (last_grant_q),
    .grant_valid (arb_valid),
    .grant       (arb_grant)
  );

  // Data path: the granted stream is wired straight through while in XFER,
  // everything is held at zero otherwise.
  always_comb begin
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = '0;
    grant_oh      = '0;
    grant_oh[grant_q] = 1'b1;
    if (state_q == ST_XFER) begin
      for (int i = 0; i < N; i++) begin
        if (grant_q == GW'(i)) begin
          m_axis_tvalid    = s_axis_tvalid[i];
          m_axis_tdata     = s_axis_tdata[i*W +: W];
          m_axis_tkeep     = s_axis_tkeep[i*KW +: KW];
          m_axis_tlast     = s_axis_tlast[i];
          s_axis_tready[i] = m_axis_tready;
        end
      end
    end
  end

  assign pkt_end    = m_axis_tvalid & m_axis_tready & m_axis_tlast;
  assign served_now = served_q | grant_oh;

  // Next-state and control outputs.
  always_comb begin
    state_d      = state_q;
    served_d     = served_q;
    round_d      = round_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    ap_idle      = 1'b0;
    ap_done      = 1'b0;
    gen_start    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        ap_idle = 1'b1;
        if (ap_start) begin
          state_d  = ST_START;
          round_d  = '0;
          served_d = '0;
        end
      end
      ST_START: begin
        gen_start = 1'b1;
        state_d   = ST_ARB;
      end
      ST_ARB: begin
        if (arb_valid) begin
          grant_d      = arb_grant;
          last_grant_d = arb_grant;
          state_d      = ST_XFER;
        end
      end
      ST_XFER: begin
        // The grant stays locked until the packet's tlast beat is accepted.
        if (pkt_end) begin
          served_d = served_now;
          if (&served_now) begin
            if (round_q == RW'(C_NUM_ROUNDS - 1)) begin
              state_d = ST_DONE;
            end else begin
              round_d  = round_q + 1'b1;
              served_d = '0;
              state_d  = ST_START;
            end
          end else begin
            state_d = ST_ARB;
          end
        end
      end
      ST_DONE: begin
        ap_done = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state_q      <= ST_IDLE;
      served_q     <= '0;
      round_q      <= '0;
      grant_q      <= '0;
      last_grant_q <= GW'(N - 1);
    end else begin
      state_q      <= state_d;
      served_q     <= served_d;
      round_q      <= round_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: tb/tb_finn_rtl_krnl_example_stream_scheduler.sv
module tb_finn_rtl_krnl_example_stream_scheduler;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int KW = W / 8;
  localparam int R  = 2;

  logic            aclk = 1'b0;
  logic            areset_n = 1'b0;
  logic            ap_start = 1'b0;
  logic            ap_idle, ap_done, gen_start;
  logic [N-1:0]    s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [N*W-1:0]  s_axis_tdata;
  logic [N*KW-1:0] s_axis_tkeep;
  logic            m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [W-1:0]    m_axis_tdata;
  logic [KW-1:0]   m_axis_tkeep;

  finn_rtl_krnl_example_stream_scheduler #(
    .C_NUM_STREAMS        (N),
    .C_M_AXIS_TDATA_WIDTH (W),
    .C_NUM_ROUNDS         (R)
  ) dut (
    .aclk          (aclk),
    .areset_n      (areset_n),
    .ap_start      (ap_start),
    .ap_idle       (ap_idle),
    .ap_done       (ap_done),
    .gen_start     (gen_start),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [W-1:0]  d;
    logic [KW-1:0] k;
    logic          l;
  } beat_t;

  typedef struct packed {
    logic [1:0]    s;
    logic [W-1:0]  d;
    logic [KW-1:0] k;
    logic          l;
    logic          dn;
  } exp_t;

  beat_t        sq [N][$];
  exp_t         expq[$];
  logic [N-1:0] hs = '0;
  bit           bp_en = 1'b0;
  bit           gap_en = 1'b0;
  int           n_vec = 0;
  int           n_err = 0;
  int           beats_seen = 0;
  int           gs_cnt = 0;
  int           done_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  function automatic logic [W-1:0] mkd(input int s, input int tag, input int b);
    return {8'(s), 8'(tag), 8'(b), 8'hA5};
  endfunction

  task automatic send_pkt(input int s, input int tag, input int n, input logic [KW-1:0] lk);
    for (int b = 0; b < n; b++) begin
      beat_t x;
      x.d = mkd(s, tag, b);
      x.k = (b == n - 1) ? lk : 4'hF;
      x.l = (b == n - 1);
      sq[s].push_back(x);
    end
  endtask

  task automatic exp_pkt(input int s, input int tag, input int n, input logic [KW-1:0] lk, input bit dn);
    for (int b = 0; b < n; b++) begin
      exp_t e;
      e.s  = 2'(s);
      e.d  = mkd(s, tag, b);
      e.k  = (b == n - 1) ? lk : 4'hF;
      e.l  = (b == n - 1);
      e.dn = dn && (b == n - 1);
      expq.push_back(e);
    end
  endtask

  task automatic start_run;
    @(negedge aclk);
    ap_start = 1'b1;
    @(negedge aclk);
    ap_start = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int t = 0;
    while (done_cnt < target && t < 3000) begin
      @(negedge aclk);
      #3;
      t++;
    end
    if (done_cnt < target) begin
      n_vec++;
      n_err++;
      $display("FAIL run_done: got %0d ap_done pulses expected %0d", done_cnt, target);
    end
  endtask

  // Generator models: each stream replays its queue, holding a beat until accepted.
  initial begin
    s_axis_tvalid = '0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tlast  = '0;
    m_axis_tready = 1'b1;
    forever begin
      @(negedge aclk);
      for (int i = 0; i < N; i++) begin
        logic  pend;
        beat_t junk;
        pend = s_axis_tvalid[i] & ~hs[i];
        if (hs[i] && sq[i].size() > 0) junk = sq[i].pop_front();
        if (sq[i].size() > 0 && (pend || !gap_en || $urandom_range(0, 3) != 0)) begin
          s_axis_tvalid[i]          = 1'b1;
          s_axis_tdata[i*W +: W]    = sq[i][0].d;
          s_axis_tkeep[i*KW +: KW]  = sq[i][0].k;
          s_axis_tlast[i]           = sq[i][0].l;
        end else begin
          s_axis_tvalid[i]          = 1'b0;
          s_axis_tdata[i*W +: W]    = '0;
          s_axis_tkeep[i*KW +: KW]  = '0;
          s_axis_tlast[i]           = 1'b0;
        end
      end
      m_axis_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      hs = s_axis_tvalid & s_axis_tready;
    end
  end

  // Monitor / scoreboard.
  initial begin
    logic        prev_stall;
    logic [37:0] prev_bus;
    bit          gap_next, done_next, gs_prev;
    exp_t        e;
    prev_stall = 1'b0;
    prev_bus   = '0;
    gap_next   = 1'b0;
    done_next  = 1'b0;
    gs_prev    = 1'b0;
    forever begin
      @(negedge aclk);
      #2;
      if (!areset_n) begin
        prev_stall = 1'b0;
        gap_next   = 1'b0;
        done_next  = 1'b0;
        gs_prev    = 1'b0;
      end else begin
        if (gen_start) begin
          gs_cnt++;
          chk("gen_start_gap", 64'(gs_prev), 64'd0);
        end
        gs_prev = gen_start;
        if (ap_done || done_next) chk("ap_done_pulse", 64'(ap_done), 64'(done_next));
        if (ap_done) done_cnt++;
        done_next = 1'b0;
        if (gap_next) chk("arb_gap_tvalid", 64'(m_axis_tvalid), 64'd0);
        gap_next = 1'b0;
        if (prev_stall)
          chk("stall_hold", 64'({m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata}), 64'(prev_bus));
        if (|s_axis_tready) chk("tready_onehot", 64'($countones(s_axis_tready)), 64'd1);
        if (m_axis_tvalid && m_axis_tready) begin
          beats_seen++;
          if (expq.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_beat: got tdata %0h expected no beat", m_axis_tdata);
          end else begin
            e = expq.pop_front();
            chk("tdata", 64'(m_axis_tdata), 64'(e.d));
            chk("tkeep", 64'(m_axis_tkeep), 64'(e.k));
            chk("tlast", 64'(m_axis_tlast), 64'(e.l));
            chk("src_tready", 64'(s_axis_tready[e.s]), 64'd1);
            if (e.l)  gap_next  = 1'b1;
            if (e.dn) done_next = 1'b1;
          end
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_bus   = {m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata};
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int gb, db, b0, t;
    int len [N];
    len = '{1, 4, 2, 3};

    // Reset state.
    repeat (3) @(negedge aclk);
    #2;
    chk("rst_ap_idle", 64'(ap_idle), 64'd1);
    chk("rst_ap_done", 64'(ap_done), 64'd0);
    chk("rst_gen_start", 64'(gen_start), 64'd0);
    chk("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_s_tready", 64'(s_axis_tready), 64'd0);
    @(negedge aclk);
    areset_n = 1'b1;
    repeat (2) @(negedge aclk);

    // Two rounds, all streams ready, 3-beat packets: 0,1,2,3 then 0,1,2,3.
    gb = gs_cnt;
    db = done_cnt;
    for (int r = 0; r < R; r++)
      for (int s = 0; s < N; s++) begin
        send_pkt(s, r, 3, 4'hF);
        exp_pkt(s, r, 3, 4'hF, (r == 1) && (s == 3));
      end
    start_run();
    wait_done(db + 1);
    repeat (3) @(negedge aclk);
    chk("t1_gen_starts", 64'(gs_cnt - gb), 64'd2);
    chk("t1_drained", 64'(expq.size()), 64'd0);
    chk("t1_idle", 64'(ap_idle), 64'd1);

    // Sparse arrival: 2 alone, then 0, then 1 and 3 -> 2,0,1,3 then 0,1,2,3.
    gb = gs_cnt;
    db = done_cnt;
    send_pkt(2, 0, 2, 4'hF);
    exp_pkt(2, 0, 2, 4'hF, 0);
    start_run();
    repeat (10) @(negedge aclk);
    #3;
    chk("t3_arb_wait_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("t3_arb_wait_busy", 64'(ap_idle), 64'd0);
    chk("t3_s2_done", 64'(expq.size()), 64'd0);
    send_pkt(0, 0, 2, 4'hF);
    exp_pkt(0, 0, 2, 4'hF, 0);
    repeat (8) @(negedge aclk);
    send_pkt(1, 0, 2, 4'hF);
    send_pkt(3, 0, 2, 4'hF);
    exp_pkt(1, 0, 2, 4'hF, 0);
    exp_pkt(3, 0, 2, 4'hF, 0);
    for (int s = 0; s < N; s++) begin
      send_pkt(s, 1, 2, 4'hF);
      exp_pkt(s, 1, 2, 4'hF, s == 3);
    end
    wait_done(db + 1);
    repeat (3) @(negedge aclk);
    chk("t3_gen_starts", 64'(gs_cnt - gb), 64'd2);
    chk("t3_drained", 64'(expq.size()), 64'd0);

    // Random backpressure and source gaps, mixed packet lengths.
    db = done_cnt;
    bp_en  = 1'b1;
    gap_en = 1'b1;
    for (int r = 0; r < R; r++)
      for (int s = 0; s < N; s++) begin
        send_pkt(s, 4 + r, len[s], 4'hF);
        exp_pkt(s, 4 + r, len[s], 4'hF, (r == 1) && (s == 3));
      end
    start_run();
    wait_done(db + 1);
    bp_en  = 1'b0;
    gap_en = 1'b0;
    repeat (3) @(negedge aclk);
    chk("t4_drained", 64'(expq.size()), 64'd0);

    // Asynchronous reset in the middle of stream 1's packet.
    b0 = beats_seen;
    send_pkt(0, 6, 3, 4'hF);
    exp_pkt(0, 6, 3, 4'hF, 0);
    send_pkt(1, 6, 8, 4'hF);
    exp_pkt(1, 6, 8, 4'hF, 0);
    start_run();
    t = 0;
    while (beats_seen < b0 + 5 && t < 300) begin
      @(negedge aclk);
      #3;
      t++;
    end
    chk("t5_reached_s1", 64'(beats_seen >= b0 + 5), 64'd1);
    areset_n = 1'b0;
    #1;
    chk("t5_rst_ap_idle", 64'(ap_idle), 64'd1);
    chk("t5_rst_ap_done", 64'(ap_done), 64'd0);
    chk("t5_rst_gen_start", 64'(gen_start), 64'd0);
    chk("t5_rst_s_tready", 64'(s_axis_tready), 64'd0);
    chk("t5_rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("t5_rst_m_tdata", 64'(m_axis_tdata), 64'd0);
    chk("t5_rst_m_tlast", 64'(m_axis_tlast), 64'd0);
    for (int s = 0; s < N; s++) sq[s].delete();
    expq.delete();
    hs = '0;
    repeat (3) @(negedge aclk);
    areset_n = 1'b1;
    @(negedge aclk);
    #3;
    chk("t5_post_idle", 64'(ap_idle), 64'd1);
    gb = gs_cnt;
    db = done_cnt;
    for (int r = 0; r < R; r++)
      for (int s = 0; s < N; s++) begin
        send_pkt(s, 8 + r, 2, 4'hF);
        exp_pkt(s, 8 + r, 2, 4'hF, (r == 1) && (s == 3));
      end
    start_run();
    wait_done(db + 1);
    repeat (3) @(negedge aclk);
    chk("t5_gen_starts", 64'(gs_cnt - gb), 64'd2);
    chk("t5_drained", 64'(expq.size()), 64'd0);

    // ap_start held high: ignored while busy, immediate restart; partial tkeep.
    gb = gs_cnt;
    db = done_cnt;
    for (int tg = 0; tg < 4; tg++)
      for (int s = 0; s < N; s++) begin
        logic [KW-1:0] lk;
        lk = (s == 2) ? 4'b0111 : (s == 3) ? 4'b0001 : 4'hF;
        send_pkt(s, 12 + tg, 2, lk);
        exp_pkt(s, 12 + tg, 2, lk, (s == 3) && (tg % 2 == 1));
      end
    @(negedge aclk);
    ap_start = 1'b1;
    wait_done(db + 1);
    chk("t6_busy_ignored", 64'(gs_cnt - gb), 64'd2);
    @(negedge aclk);
    #3;
    chk("t6_restart_idle", 64'(ap_idle), 64'd1);
    @(negedge aclk);
    #3;
    chk("t6_restart_start", 64'(gen_start), 64'd1);
    ap_start = 1'b0;
    wait_done(db + 2);
    repeat (3) @(negedge aclk);
    chk("t6_gen_starts", 64'(gs_cnt - gb), 64'd4);
    chk("t6_done_pulses", 64'(done_cnt - db), 64'd2);
    chk("t6_drained", 64'(expq.size()), 64'd0);
    chk("t6_idle", 64'(ap_idle), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
